// File: rtl/serializer.sv
// serializer
//   Wide-to-narrow serializer. Accepts in_bit_width-wide words over a valid/ready
//   handshake and emits them least-significant segment first as out_bit_width
//   segments over the data_ready/read_data handshake. A one-deep pending buffer
//   lets back-to-back words stream at one segment per cycle.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high reset
//   wr_valid    in   upstream presents a wide word on data_in
//   wr_ready    out  a wide word can be accepted this cycle
//   data_in     in   wide word, sampled on wr_valid & wr_ready
//   data_ready  out  a segment is valid on data_out
//   read_data   in   downstream consumes the current segment
//   data_out    out  current segment
//   last_seg    out  current segment is the final one of its word
module serializer #(
    parameter int unsigned in_bit_width  = 512,
    parameter int unsigned out_bit_width = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [in_bit_width-1:0]  data_in,
    output logic                     data_ready,
    input  logic                     read_data,
    output logic [out_bit_width-1:0] data_out,
    output logic                     last_seg
);

    localparam int unsigned NUM_SEG = in_bit_width / out_bit_width;
    localparam int unsigned SEG_BW  = $clog2(NUM_SEG);
    localparam logic [SEG_BW-1:0] LAST_IDX = SEG_BW'(NUM_SEG - 1);

    typedef enum logic [1:0] {
        StEmpty,
        StActive,
        StFull
    } state_e;

    state_e                  r_state;
    logic [SEG_BW-1:0]       r_seg_cnt;
    logic [in_bit_width-1:0] r_active_buf;
    logic [in_bit_width-1:0] r_pending_buf;

    state_e                  w_state_d;
    logic [SEG_BW-1:0]       w_seg_cnt_d;
    logic [in_bit_width-1:0] w_active_buf_d;
    logic [in_bit_width-1:0] w_pending_buf_d;

    logic w_acc;
    logic w_rd;
    logic w_fin;

    // Segment view of the active word; index 0 is the least-significant slice.
    logic [NUM_SEG-1:0][out_bit_width-1:0] w_segs;

    assign w_segs     = r_active_buf;
    assign wr_ready   = !reset && (r_state != StFull);
    assign data_ready = (r_state != StEmpty);
    assign data_out   = w_segs[r_seg_cnt];
    assign last_seg   = data_ready && (r_seg_cnt == LAST_IDX);

    assign w_acc = wr_valid && wr_ready;
    assign w_rd  = read_data && data_ready;
    assign w_fin = w_rd && (r_seg_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StEmpty;
            r_seg_cnt     <= '0;
            r_active_buf  <= '0;
            r_pending_buf <= '0;
        end else begin
            r_state       <= w_state_d;
            r_seg_cnt     <= w_seg_cnt_d;
            r_active_buf  <= w_active_buf_d;
            r_pending_buf <= w_pending_buf_d;
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_active_buf_d  = r_active_buf;
        w_pending_buf_d = r_pending_buf;
        // NUM_SEG is a power of two, so the counter wraps to 0 naturally.
        w_seg_cnt_d     = w_rd ? r_seg_cnt + SEG_BW'(1) : r_seg_cnt;

        unique case (r_state)
            StEmpty: begin
                if (w_acc) begin
                    w_active_buf_d = data_in;
                    w_state_d      = StActive;
                end
            end
            StActive: begin
                if (w_fin && w_acc) begin
                    // Bypass: new word goes straight to active, no bubble.
                    w_active_buf_d = data_in;
                end else if (w_fin) begin
                    w_state_d = StEmpty;
                end else if (w_acc) begin
                    w_pending_buf_d = data_in;
                    w_state_d       = StFull;
                end
            end
            StFull: begin
                // wr_ready is low here, so only the drain can happen.
                if (w_fin) begin
                    w_active_buf_d = r_pending_buf;
                    w_state_d      = StActive;
                end
            end
            default: begin
                w_state_d = StEmpty;
            end
        endcase
    end

endmodule

// File: tb/tb_serializer.sv
// tb_serializer
//   Directed bench for serializer at 128-bit in / 32-bit out (four segments).
//   Each scenario task drives stimulus per cycle and compares outputs inline.
module tb_serializer;

    localparam int unsigned IW = 128;
    localparam int unsigned OW = 32;

    localparam logic [IW-1:0] W0 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [IW-1:0] W1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [IW-1:0] W2 = 128'h88888888_77777777_66666666_55555555;

    logic          clk;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [IW-1:0] data_in;
    logic          data_ready;
    logic          read_data;
    logic [OW-1:0] data_out;
    logic          last_seg;

    int n_cmp;
    int n_err;

    serializer #(
        .in_bit_width (IW),
        .out_bit_width(OW)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .data_in   (data_in),
        .data_ready(data_ready),
        .read_data (read_data),
        .data_out  (data_out),
        .last_seg  (last_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] seg_of(input logic [IW-1:0] w, input int i);
        return w[i*OW +: OW];
    endfunction

    // Advance to 1 time unit after the next rising edge; inputs change there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        wr_valid  = 1'b0;
        read_data = 1'b0;
        data_in   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        wr_valid  = 1'b0;
        read_data = 1'b1;
        data_in   = W0;
        step();
        #1;
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset.wr_ready got %b want 0", wr_ready);
        end
        n_cmp++;
        if (data_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset.data_ready got %b want 0", data_ready);
        end
        n_cmp++;
        if (data_out !== 32'h0) begin
            n_err++;
            $display("FAIL reset.data_out got %h want 00000000", data_out);
        end
        n_cmp++;
        if (last_seg !== 1'b0) begin
            n_err++;
            $display("FAIL reset.last_seg got %b want 0", last_seg);
        end
        step();
        reset     = 1'b0;
        read_data = 1'b0;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset.wr_ready_after got %b want 1", wr_ready);
        end
        step();
    endtask

    task automatic test_single();
        do_reset();
        wr_valid  = 1'b1;
        data_in   = W0;
        read_data = 1'b1;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single.accept got wr_ready=%b want 1", wr_ready);
        end
        step();
        wr_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            n_cmp++;
            if (data_ready !== (c <= 4)) begin
                n_err++;
                $display("FAIL single.data_ready c=%0d got %b want %b", c, data_ready, c <= 4);
            end
            n_cmp++;
            if (last_seg !== (c == 4)) begin
                n_err++;
                $display("FAIL single.last_seg c=%0d got %b want %b", c, last_seg, c == 4);
            end
            if (c <= 4) begin
                n_cmp++;
                if (data_out !== seg_of(W0, c - 1)) begin
                    n_err++;
                    $display("FAIL single.data_out c=%0d got %h want %h", c, data_out,
                             seg_of(W0, c - 1));
                end
            end
            step();
        end
        read_data = 1'b0;
    endtask

    task automatic test_stream();
        logic [IW-1:0] w;
        do_reset();
        wr_valid  = 1'b1;
        data_in   = W0;
        read_data = 1'b1;
        step();
        for (int c = 1; c <= 9; c++) begin
            wr_valid = (c == 3);
            data_in  = W1;
            #1;
            n_cmp++;
            if (data_ready !== (c <= 8)) begin
                n_err++;
                $display("FAIL stream.data_ready c=%0d got %b want %b", c, data_ready, c <= 8);
            end
            if (c <= 8) begin
                w = (c <= 4) ? W0 : W1;
                n_cmp++;
                if (data_out !== seg_of(w, (c - 1) % 4)) begin
                    n_err++;
                    $display("FAIL stream.data_out c=%0d got %h want %h", c, data_out,
                             seg_of(w, (c - 1) % 4));
                end
                n_cmp++;
                if (wr_ready !== (c != 4)) begin
                    n_err++;
                    $display("FAIL stream.wr_ready c=%0d got %b want %b", c, wr_ready, c != 4);
                end
            end
            step();
        end
        wr_valid  = 1'b0;
        read_data = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] exp_seg [2:7];
        logic          exp_last[2:7];
        exp_seg = '{32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222,
                    32'h33333333, 32'h44444444};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        wr_valid  = 1'b1;
        data_in   = W0;
        read_data = 1'b1;
        step();
        wr_valid = 1'b0;
        step();
        for (int c = 2; c <= 7; c++) begin
            read_data = (c >= 5);
            #1;
            n_cmp++;
            if (data_out !== exp_seg[c]) begin
                n_err++;
                $display("FAIL bp.data_out c=%0d got %h want %h", c, data_out, exp_seg[c]);
            end
            n_cmp++;
            if (last_seg !== exp_last[c]) begin
                n_err++;
                $display("FAIL bp.last_seg c=%0d got %b want %b", c, last_seg, exp_last[c]);
            end
            step();
        end
        #1;
        n_cmp++;
        if (data_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp.drained got data_ready=%b want 0", data_ready);
        end
        read_data = 1'b0;
    endtask

    task automatic test_full_stall();
        logic [IW-1:0] w;
        do_reset();
        wr_valid  = 1'b1;
        data_in   = W0;
        read_data = 1'b0;
        step();
        data_in = W1;
        step();
        data_in = W2;
        for (int c = 2; c <= 3; c++) begin
            #1;
            n_cmp++;
            if (wr_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall.wr_ready c=%0d got %b want 0", c, wr_ready);
            end
            n_cmp++;
            if (data_out !== 32'h11111111) begin
                n_err++;
                $display("FAIL stall.hold c=%0d got %h want 11111111", c, data_out);
            end
            step();
        end
        read_data = 1'b1;
        for (int c = 4; c <= 16; c++) begin
            wr_valid = (c <= 8);
            #1;
            n_cmp++;
            if (data_ready !== (c <= 15)) begin
                n_err++;
                $display("FAIL stall.data_ready c=%0d got %b want %b", c, data_ready, c <= 15);
            end
            if (c <= 15) begin
                w = ((c - 4) < 4) ? W0 : (((c - 4) < 8) ? W1 : W2);
                n_cmp++;
                if (data_out !== seg_of(w, (c - 4) % 4)) begin
                    n_err++;
                    $display("FAIL stall.data_out c=%0d got %h want %h", c, data_out,
                             seg_of(w, (c - 4) % 4));
                end
                n_cmp++;
                if (wr_ready !== (c == 8 || c >= 12)) begin
                    n_err++;
                    $display("FAIL stall.wr_ready c=%0d got %b want %b", c, wr_ready,
                             c == 8 || c >= 12);
                end
            end
            step();
        end
        wr_valid  = 1'b0;
        read_data = 1'b0;
    endtask

    task automatic test_bypass();
        do_reset();
        wr_valid  = 1'b1;
        data_in   = W0;
        read_data = 1'b1;
        step();
        wr_valid = 1'b0;
        step();
        step();
        step();
        // Cycle 4: final segment of W0 consumed while W1 is offered.
        wr_valid = 1'b1;
        data_in  = W1;
        #1;
        n_cmp++;
        if (last_seg !== 1'b1 || wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bypass.setup got last_seg=%b wr_ready=%b want 1 1", last_seg, wr_ready);
        end
        step();
        wr_valid = 1'b0;
        for (int c = 5; c <= 9; c++) begin
            #1;
            n_cmp++;
            if (data_ready !== (c <= 8)) begin
                n_err++;
                $display("FAIL bypass.data_ready c=%0d got %b want %b", c, data_ready, c <= 8);
            end
            if (c <= 8) begin
                n_cmp++;
                if (data_out !== seg_of(W1, c - 5) || last_seg !== (c == 8)) begin
                    n_err++;
                    $display("FAIL bypass.seg c=%0d got %h/%b want %h/%b", c, data_out, last_seg,
                             seg_of(W1, c - 5), c == 8);
                end
                n_cmp++;
                if (wr_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL bypass.wr_ready c=%0d got %b want 1", c, wr_ready);
                end
            end
            step();
        end
        read_data = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr_valid  = 1'b1;
        data_in   = W0;
        read_data = 1'b1;
        step();
        data_in = W1;
        step();
        wr_valid = 1'b0;
        step();
        // Cycle 3: W0 segment 2 on the output, W1 pending.
        #1;
        n_cmp++;
        if (data_out !== 32'h33333333 || wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid.setup got %h wr_ready=%b want 33333333 0", data_out, wr_ready);
        end
        reset = 1'b1;
        step();
        reset    = 1'b0;
        wr_valid = 1'b1;
        data_in  = W2;
        #1;
        n_cmp++;
        if (data_ready !== 1'b0 || data_out !== 32'h0 || last_seg !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid.cleared got dr=%b do=%h ls=%b want 0 00000000 0",
                     data_ready, data_out, last_seg);
        end
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid.wr_ready got %b want 1", wr_ready);
        end
        step();
        wr_valid = 1'b0;
        for (int c = 5; c <= 9; c++) begin
            #1;
            n_cmp++;
            if (data_ready !== (c <= 8)) begin
                n_err++;
                $display("FAIL rstmid.data_ready c=%0d got %b want %b", c, data_ready, c <= 8);
            end
            if (c <= 8) begin
                n_cmp++;
                if (data_out !== seg_of(W2, c - 5)) begin
                    n_err++;
                    $display("FAIL rstmid.data_out c=%0d got %h want %h", c, data_out,
                             seg_of(W2, c - 5));
                end
            end
            step();
        end
        read_data = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        wr_valid  = 1'b0;
        read_data = 1'b0;
        data_in   = '0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_full_stall();
        test_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serializer.md
# serializer

Wide-to-narrow serializer that is the upstream neighbour of the deserializer in the SerDes link. It accepts full-width words over a valid/ready handshake and emits them as narrow segments over the `data_ready`/`read_data` handshake the deserializer consumes. Segments are emitted least-significant first. A one-deep pending register hides the reload bubble, so back-to-back wide words stream at one segment per cycle.

## Interface
- `in_bit_width`, default 512: width of the wide input word.
- `out_bit_width`, default 32: width of one output segment. `in_bit_width/out_bit_width` is NUM_SEG, which must be an integer, a power of two and ≥ 2. SEG_BW = $clog2(NUM_SEG).
- `clk`  input  1  clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `wr_valid`  input  1  upstream presents a wide word on `data_in`.
- `wr_ready`  output  1  block can accept a wide word this cycle.
- `data_in`  input  in_bit_width  wide word; sampled only when `wr_valid & wr_ready`.
- `data_ready`  output  1  a segment is valid on `data_out`.
- `read_data`  input  1  downstream consumes the current segment this cycle.
- `data_out`  output  out_bit_width  current segment.
- `last_seg`  output  1  the current segment is the final one (index NUM_SEG-1) of its word.

## Operation
- Storage:
  - `active_buf` holds the word being serialized; `pending_buf` holds the next word.
  - `seg_cnt` is SEG_BW bits wide.
  - `state` is one of EMPTY, ACTIVE, FULL.
- Definitions:
  - acc = `wr_valid & wr_ready`.
  - rd = `read_data & data_ready`. `read_data` while `data_ready` is 0 is ignored.
  - fin = rd & (`seg_cnt` == NUM_SEG-1).
- Combinational outputs:
  - `wr_ready` = !reset & (state != FULL).
  - `data_ready` = (state != EMPTY).
  - `data_out` = `active_buf[seg_cnt*out_bit_width +: out_bit_width]`.
  - `last_seg` = `data_ready` & (`seg_cnt` == NUM_SEG-1).
- Counter: when rd, `seg_cnt` increments and wraps from NUM_SEG-1 to 0. Otherwise it holds. Any load of `active_buf` coincides with a wrap or with `seg_cnt` already at 0, so every word starts at segment 0.
- Transitions:
  - EMPTY, acc: `active_buf` ← `data_in`; go to ACTIVE.
  - EMPTY, no acc: stay in EMPTY.
  - ACTIVE, fin & acc: `active_buf` ← `data_in`; stay in ACTIVE. This is the bypass and creates no bubble.
  - ACTIVE, fin & !acc: go to EMPTY.
  - ACTIVE, !fin & acc: `pending_buf` ← `data_in`; go to FULL.
  - ACTIVE, otherwise: stay in ACTIVE.
  - FULL, fin: `active_buf` ← `pending_buf`; go to ACTIVE. acc cannot occur in FULL.
  - FULL, otherwise: stay in FULL.
- Word order is preserved: a word is never overwritten before its final segment is consumed.
- Reset (takes priority over everything):
  - state → EMPTY, `seg_cnt` → 0, both buffers → 0.
  - Outputs while reset is asserted and the cycle after: `wr_ready` 0 then 1, `data_ready` 0, `data_out` 0, `last_seg` 0.
  - Reset mid-word discards `active_buf` and `pending_buf` contents; no partial segments are emitted afterwards.

## Timing
- Accept latency: a word accepted in cycle N (state EMPTY) presents segment 0 with `data_ready`=1 in cycle N+1.
- Segment hold: each segment stays stable on `data_out` until the cycle it is consumed. `data_ready` never deasserts mid-word except on reset.
- Throughput: with `read_data` held high and `wr_valid` asserted once per NUM_SEG cycles, `data_ready` stays high continuously, one segment per cycle.
- `wr_ready` is 0 exactly while FULL. It rises in the cycle after the fin that drains the pending word.
- Simultaneous fin and acc in ACTIVE: the new word's segment 0 appears in the next cycle.
- Simultaneous fin and acc in FULL: impossible, because `wr_ready` is 0.

## Test plan
Use `in_bit_width`=128, `out_bit_width`=32, word W0=128'h44444444_33333333_22222222_11111111.
- Single word:
  - Stimulus: reset, then W0 accepted in cycle 0 with `read_data`=1 throughout.
  - Required: `data_out` = 11111111, 22222222, 33333333, 44444444 in cycles 1–4.
  - Required: `last_seg`=1 only in cycle 4; `data_ready`=0 in cycle 5.
- Streaming:
  - Stimulus: W0, then W1=128'hDDDD…_AAAA… with W1 offered at cycle 3 (accepted into pending).
  - Required: 8 consecutive segments in order, no bubble.
  - Required: `wr_ready`=0 from cycle 4 until the cycle after W0's last segment.
- Backpressure:
  - Stimulus: W0 with `read_data`=0 for 3 cycles at segment 1.
  - Required: `data_out` holds 22222222 and `seg_cnt` does not advance.
  - Required: stream resumes correctly when `read_data` returns high.
- Full stall:
  - Stimulus: W0 and W1 accepted, `read_data`=0; then offer W2.
  - Required: `wr_ready`=0 and W2 is not accepted.
  - Required: after `read_data` is released, output is W0 then W1, and W2 is accepted after W0 drains.
- Bypass:
  - Stimulus: in ACTIVE at segment 3, `read_data`=1 and `wr_valid`=1 with W1 in the same cycle.
  - Required: next cycle shows W1 segment 0 with `seg_cnt`=0; state is ACTIVE, not FULL.
- Reset mid-operation:
  - Stimulus: assert reset during W0 segment 2 with W1 pending.
  - Required: next cycle `data_ready`=0, `data_out`=0, `last_seg`=0.
  - Required: a new word W2 then starts cleanly at segment 0.
